mmcm_lock_sequencer: RTL and testbench
======================================

# mmcm_lock_sequencer

Drives the DAQ MMCM reset and consumes its lock indication. It releases a synchronous system reset only after the MMCM has shown lock continuously for a qualified interval. It runs on the free-running startup oscillator clock (STRTUP_CLK) because that clock exists before the MMCM outputs do. It retries failed lock acquisitions, counts lock losses, and latches a fault after repeated failures.

## Interface
Parameters:
- RST_CYC, 32: cycles DAQ_MMCM_RST is held high per reset pulse (≥1).
- LOCK_TO, 4096: cycles allowed in WAIT_LOCK before a retry (≥1).
- STABLE_CYC, 256: consecutive synchronized-lock cycles required before RUN (≥1).
- MAX_RETRY, 7: timeouts tolerated before FAULT (1..15).

Ports:
- CLK  in  1  STRTUP_CLK domain; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- EOS  in  1  end of configuration, level.
- DAQ_MMCM_LOCK  in  1  MMCM lock, asynchronous to CLK.
- FORCE_RESYNC  in  1  one-cycle request to re-run the MMCM reset sequence.
- DAQ_MMCM_RST  out  1  MMCM reset, registered.
- SYS_RST  out  1  fabric reset, registered; low only in RUN.
- READY  out  1  high only in RUN.
- FAULT  out  1  high only in FAULT.
- RETRY_CNT  out  4  timeouts in the current acquisition.
- LOCK_LOSS_CNT  out  8  lock drops seen in RUN; saturates at 255.
- STATE  out  3  current state encoding.

## Operation
- DAQ_MMCM_LOCK passes through a 2-FF synchronizer to produce lock_s. No other input is synchronized.
- States and encodings: WAIT_EOS=0, MMCM_RST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5. Codes 6 and 7 go to WAIT_EOS.
- One shared counter `cnt`, width clog2 of max(RST_CYC, LOCK_TO, STABLE_CYC)+1. It is cleared on every state change.
- WAIT_EOS:
  - DAQ_MMCM_RST=1.
  - When EOS=1, go to MMCM_RST.
- MMCM_RST:
  - DAQ_MMCM_RST=1; cnt increments.
  - When cnt==RST_CYC-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - DAQ_MMCM_RST=0.
  - If lock_s=1, go to STABLE.
  - Otherwise, if cnt==LOCK_TO-1, RETRY_CNT increments. The next state is FAULT if the new value equals MAX_RETRY, else MMCM_RST.
  - If lock_s=1 and timeout occur in the same cycle, lock wins.
- STABLE:
  - cnt increments while lock_s=1.
  - If lock_s=0, go to WAIT_LOCK with a fresh timeout.
  - When cnt==STABLE_CYC-1 with lock_s=1, go to RUN.
- RUN:
  - SYS_RST=0, READY=1.
  - If lock_s=0: LOCK_LOSS_CNT increments (saturating), RETRY_CNT clears, go to MMCM_RST.
  - Else if FORCE_RESYNC=1: RETRY_CNT clears, go to MMCM_RST, no loss count.
  - If both occur in the same cycle, it counts as a loss.
- FAULT:
  - DAQ_MMCM_RST=1, FAULT=1.
  - Exits only on RST, or on FORCE_RESYNC, which clears RETRY_CNT and goes to MMCM_RST.
- FORCE_RESYNC is ignored in every state except RUN and FAULT.
- EOS is sampled only in WAIT_EOS. If EOS later falls, there is no effect.

## Timing
- Outputs during RST: DAQ_MMCM_RST=1, SYS_RST=1, READY=0, FAULT=0, RETRY_CNT=0, LOCK_LOSS_CNT=0, STATE=0. Synchronizer flops and cnt are cleared.
- RST asserted mid-sequence: at the next edge, all outputs take their reset values and the state returns to WAIT_EOS. RST has priority over every transition.
- All outputs are registered. DAQ_MMCM_RST, SYS_RST, READY and FAULT change on the same edge as STATE.
- DAQ_MMCM_RST high pulse per attempt: exactly RST_CYC cycles, counted from MMCM_RST entry.
- Lock latency:
  - DAQ_MMCM_LOCK rising before edge k makes STATE=STABLE after edge k+2.
  - A drop is handled the same way, with 3-edge latency.
- Lock-to-ready latency: SYS_RST falls 2+1+STABLE_CYC edges after the LOCK rise, given no drop in between.
- Timeout: LOCK_TO cycles spent in WAIT_LOCK, then the transition on the next edge.

## Test plan
- Nominal: EOS=1 from reset; LOCK rises 10 cycles after DAQ_MMCM_RST falls. Required: DAQ_MMCM_RST high for exactly 32 cycles; SYS_RST falls 259 edges after the LOCK rise; READY=1; RETRY_CNT=0.
- Never lock: LOCK held 0. Required: 7 reset pulses spaced 32+4096 cycles apart; FAULT=1 and STATE=5 after the 7th timeout; DAQ_MMCM_RST remains 1; RETRY_CNT=7. A FORCE_RESYNC pulse then gives STATE=1 and RETRY_CNT=0.
- Glitchy lock: in STABLE, LOCK drops for 1 cycle at cnt=100. Required: return to WAIT_LOCK; after re-lock, the full 256-cycle qualification restarts; no LOCK_LOSS_CNT change.
- Lock loss in RUN: LOCK drops for 5 cycles, 300 times, with a relock after each. Required: LOCK_LOSS_CNT saturates at 255; SYS_RST=1 within 4 edges of each drop; each loss starts a 32-cycle reset.
- Simultaneous: FORCE_RESYNC and a LOCK drop arriving at the FSM in the same RUN cycle. Required: LOCK_LOSS_CNT +1. Separately, a FORCE_RESYNC in WAIT_LOCK is ignored.
- Reset mid-sequence: RST asserted at cnt=2000 of WAIT_LOCK with RETRY_CNT=3. Required: all outputs at reset values on the next edge; the sequence restarts from WAIT_EOS.

Source files
------------

// File: rtl/mmcm_lock_sequencer.sv
// MMCM reset/lock sequencer on the startup oscillator clock: pulses the MMCM
// reset, qualifies lock, releases the fabric reset, retries and latches faults.
module mmcm_lock_sequencer #(
    parameter int RST_CYC    = 32,
    parameter int LOCK_TO    = 4096,
    parameter int STABLE_CYC = 256,
    parameter int MAX_RETRY  = 7
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EOS,
    input  logic       DAQ_MMCM_LOCK,
    input  logic       FORCE_RESYNC,
    output logic       DAQ_MMCM_RST,
    output logic       SYS_RST,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] LOCK_LOSS_CNT,
    output logic [2:0] STATE
);
    localparam int MAX_A   = (RST_CYC > LOCK_TO) ? RST_CYC : LOCK_TO;
    localparam int MAX_CYC = (MAX_A > STABLE_CYC) ? MAX_A : STABLE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TO - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    localparam logic [2:0] S_WAIT_EOS  = 3'd0;
    localparam logic [2:0] S_MMCM_RST  = 3'd1;
    localparam logic [2:0] S_WAIT_LOCK = 3'd2;
    localparam logic [2:0] S_STABLE    = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             lock_meta_q, lock_s_q;
    logic             daq_rst_q, daq_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_WAIT_EOS;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            daq_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            lock_meta_q <= DAQ_MMCM_LOCK;
            lock_s_q    <= lock_meta_q;
            daq_rst_q   <= daq_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            S_WAIT_EOS: begin
                if (EOS) state_d = S_MMCM_RST;
            end
            S_MMCM_RST: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                cnt_d = cnt_q + 1'b1;
                // Lock beats a coincident timeout.
                if (lock_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == LOCK_LAST) begin
                    retry_d = retry_q + 4'd1;
                    state_d = (retry_d == RETRY_MAX) ? S_FAULT : S_MMCM_RST;
                end
            end
            S_STABLE: begin
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == STABLE_LAST) state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A loss coinciding with a resync request is still counted.
                if (!lock_s_q) begin
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    retry_d = '0;
                    state_d = S_MMCM_RST;
                end else if (FORCE_RESYNC) begin
                    retry_d = '0;
                    state_d = S_MMCM_RST;
                end
            end
            S_FAULT: begin
                if (FORCE_RESYNC) begin
                    retry_d = '0;
                    state_d = S_MMCM_RST;
                end
            end
            default: state_d = S_WAIT_EOS;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Decoded from the next state so the flags move on the same edge as STATE.
    always_comb begin
        daq_rst_d = 1'b1;
        sys_rst_d = 1'b1;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
        case (state_d)
            S_WAIT_LOCK, S_STABLE: daq_rst_d = 1'b0;
            S_RUN: begin
                daq_rst_d = 1'b0;
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            S_FAULT: fault_d = 1'b1;
            default: ;
        endcase
    end

    assign DAQ_MMCM_RST  = daq_rst_q;
    assign SYS_RST       = sys_rst_q;
    assign READY         = ready_q;
    assign FAULT         = fault_q;
    assign RETRY_CNT     = retry_q;
    assign LOCK_LOSS_CNT = loss_q;
    assign STATE         = state_q;
endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Scoreboard bench: scenario tasks predict every output transition (cycle and
// value) from lock/reset timing rules; a negedge monitor pops and compares.
module tb_mmcm_lock_sequencer;
    localparam int RST_CYC    = 8;
    localparam int LOCK_TO    = 64;
    localparam int STABLE_CYC = 16;
    localparam int MAX_RETRY  = 7;

    localparam logic [2:0] S_WAIT_EOS  = 3'd0;
    localparam logic [2:0] S_MMCM_RST  = 3'd1;
    localparam logic [2:0] S_WAIT_LOCK = 3'd2;
    localparam logic [2:0] S_STABLE    = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    logic       CLK = 1'b0;
    logic       RST, EOS, LOCK, FORCE;
    logic       DAQ_MMCM_RST, SYS_RST, READY, FAULT;
    logic [3:0] RETRY_CNT;
    logic [7:0] LOCK_LOSS_CNT;
    logic [2:0] STATE;

    always #5 CLK = ~CLK;

    mmcm_lock_sequencer #(
        .RST_CYC(RST_CYC), .LOCK_TO(LOCK_TO),
        .STABLE_CYC(STABLE_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .CLK(CLK), .RST(RST), .EOS(EOS), .DAQ_MMCM_LOCK(LOCK),
        .FORCE_RESYNC(FORCE), .DAQ_MMCM_RST(DAQ_MMCM_RST), .SYS_RST(SYS_RST),
        .READY(READY), .FAULT(FAULT), .RETRY_CNT(RETRY_CNT),
        .LOCK_LOSS_CNT(LOCK_LOSS_CNT), .STATE(STATE)
    );

    typedef struct {
        int          cyc;
        logic [18:0] v;
    } exp_t;
    exp_t exp_q[$];

    int   cyc;
    logic rst_at_edge = 1'b0;
    always @(posedge CLK) begin
        cyc         <= cyc + 1;
        rst_at_edge <= RST;
    end

    localparam logic [18:0] RST_V = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    wire [18:0] cur_v = {STATE, DAQ_MMCM_RST, SYS_RST, READY, FAULT, RETRY_CNT, LOCK_LOSS_CNT};

    int          checks, errors;
    logic        mon_en = 1'b0, done = 1'b0, fin_chk = 1'b0;
    logic [18:0] prev_v;

    always @(negedge CLK) begin
        exp_t e;
        if (rst_at_edge) begin
            checks++;
            if (cur_v !== RST_V) begin
                errors++;
                $display("FAIL reset_values cyc=%0d got=%h exp=%h", cyc, cur_v, RST_V);
            end
        end
        if (mon_en) begin
            if (cur_v !== prev_v) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].cyc > cyc) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%h prev=%h", cyc, cur_v, prev_v);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || cur_v !== e.v) begin
                        errors++;
                        $display("FAIL transition cyc=%0d got=%h exp=%h exp_cyc=%0d", cyc, cur_v, e.v, e.cyc);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL missed_transition cyc=%0d got=%h exp=%h exp_cyc=%0d", cyc, cur_v, e.v, e.cyc);
            end
        end
        if (done && !fin_chk) begin
            fin_chk = 1'b1;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL pending_expectations got=%0d exp=0", exp_q.size());
            end
        end
        prev_v = cur_v;
    end

    int m_retry, m_loss, m_wl, m_run, m_last;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    // Expected outputs are a function of the state plus the two counters.
    task automatic push(input int c, input logic [2:0] st);
        exp_t e;
        e.cyc = c;
        e.v = {st, (st == S_WAIT_EOS || st == S_MMCM_RST || st == S_FAULT),
               (st != S_RUN), (st == S_RUN), (st == S_FAULT), 4'(m_retry), 8'(m_loss)};
        exp_q.push_back(e);
        m_last = c;
    endtask

    task automatic enter_rst(input int e);
        m_wl = e + RST_CYC;
        push(m_wl, S_WAIT_LOCK);
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // LOCK change driven after edge n reaches the FSM at edge n+3.
    task automatic acquire(input int delay, input bit glitch);
        int n, s, d, gl;
        n = m_wl + delay;
        s = n + 3;
        push(s, S_STABLE);
        if (glitch) begin
            d  = s + int'($urandom_range(0, STABLE_CYC - 4));
            gl = int'($urandom_range(1, 4));
            push(d + 3, S_WAIT_LOCK);
            s = d + gl + 3;
            push(s, S_STABLE);
        end
        m_run = s + STABLE_CYC;
        push(m_run, S_RUN);
        wait_until(n);
        LOCK = 1'b1;
        if (glitch) begin
            wait_until(d);
            LOCK = 1'b0;
            wait_until(d + gl);
            LOCK = 1'b1;
        end
        wait_until(m_run);
    endtask

    task automatic lose(input bit force_too);
        int d, w, st;
        d = cyc + int'($urandom_range(0, 5));
        m_loss  = sat_inc(m_loss);
        m_retry = 0;
        push(d + 3, S_MMCM_RST);
        w = d + 3 + RST_CYC;
        push(w, S_WAIT_LOCK);
        st = (w + 1 > d + 8) ? w + 1 : d + 8;
        push(st, S_STABLE);
        m_run = st + STABLE_CYC;
        push(m_run, S_RUN);
        wait_until(d);
        LOCK = 1'b0;
        if (force_too) begin
            wait_until(d + 2);
            FORCE = 1'b1;
            tick();
            FORCE = 1'b0;
        end
        wait_until(d + 5);
        LOCK = 1'b1;
        wait_until(m_run);
    endtask

    task automatic resync_run();
        int n, w;
        n = cyc + int'($urandom_range(1, 5));
        m_retry = 0;
        push(n + 1, S_MMCM_RST);
        w = n + 1 + RST_CYC;
        push(w, S_WAIT_LOCK);
        push(w + 1, S_STABLE);
        m_run = w + 1 + STABLE_CYC;
        push(m_run, S_RUN);
        wait_until(n);
        FORCE = 1'b1;
        tick();
        FORCE = 1'b0;
        wait_until(m_run);
    endtask

    task automatic lose_hold();
        int d;
        d = cyc + int'($urandom_range(0, 5));
        m_loss  = sat_inc(m_loss);
        m_retry = 0;
        push(d + 3, S_MMCM_RST);
        enter_rst(d + 3);
        wait_until(d);
        LOCK = 1'b0;
    endtask

    task automatic never_lock(input int tmax, input bit poke);
        int t, first_wl;
        first_wl = m_wl;
        for (int k = 0; k < tmax; k++) begin
            t = m_wl + LOCK_TO;
            m_retry++;
            if (m_retry == MAX_RETRY) begin
                push(t, S_FAULT);
                break;
            end
            push(t, S_MMCM_RST);
            enter_rst(t);
        end
        if (poke) begin
            wait_until(first_wl + 5);
            FORCE = 1'b1;
            tick();
            FORCE = 1'b0;
        end
        wait_until(m_last);
    endtask

    task automatic fault_exit();
        int n;
        wait_until(cyc + 2);
        LOCK = 1'b1;
        wait_until(cyc + 3);
        LOCK = 1'b0;
        n = cyc + int'($urandom_range(2, 8));
        m_retry = 0;
        push(n + 1, S_MMCM_RST);
        enter_rst(n + 1);
        wait_until(n);
        FORCE = 1'b1;
        tick();
        FORCE = 1'b0;
    endtask

    task automatic reset_mid();
        int n, m;
        wait_until(m_wl + int'($urandom_range(10, LOCK_TO - 10)));
        n = cyc;
        m_retry = 0;
        m_loss  = 0;
        push(n + 1, S_WAIT_EOS);
        RST = 1'b1;
        wait_until(n + 1 + int'($urandom_range(1, 3)));
        m = cyc;
        push(m + 1, S_MMCM_RST);
        enter_rst(m + 1);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; EOS = 1'b0; LOCK = 1'b0; FORCE = 1'b0;
        m_retry = 0; m_loss = 0;
        repeat (3) tick();
        RST = 1'b0;
        mon_en = 1'b1;
        wait_until(cyc + int'($urandom_range(3, 10)));
        EOS = 1'b1;
        push(cyc + 1, S_MMCM_RST);
        enter_rst(cyc + 1);
        acquire(10, 1'b0);
        resync_run();
        lose(1'b1);
        EOS = 1'b0;
        lose(1'b0);
        lose_hold();
        never_lock(MAX_RETRY, 1'b1);
        fault_exit();
        acquire(int'($urandom_range(0, 20)), 1'b1);
        for (int i = 0; i < 300; i++) lose($urandom_range(0, 3) == 0);
        EOS = 1'b1;
        lose_hold();
        never_lock(3, 1'b0);
        reset_mid();
        acquire(int'($urandom_range(0, 20)), 1'b0);
        wait_until(cyc + 5);
        done = 1'b1;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
